// File: rtl/mm_operand_loader.sv
// mm_operand_loader: collects DIM*DIM elements of A and then of B, one byte per
// strobe rise, launches the multiplier core with a one-cycle start pulse and
// keeps both operand matrices frozen until the core reports done.
//
// Handshake with the core: start is a registered one-cycle pulse, raised only
// while core_busy is low; the loader then sits in RUN until core_done pulses
// (core_busy is not looked at in RUN). Bytes arrive on data_in and are
// qualified by a rising edge on the asynchronous strobe_in pin, after a
// three-flop synchroniser; data_in must stay stable until the capture edge.
module mm_operand_loader #(
  parameter  int DIM   = 2,
  parameter  int WIDTH = 8,
  localparam int NELEM = 2 * DIM * DIM,
  localparam int CW    = $clog2(NELEM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       strobe_in,
  input  logic                       clear,
  input  logic                       core_busy,
  input  logic                       core_done,
  output logic [DIM*DIM*WIDTH-1:0]   mat_a,
  output logic [DIM*DIM*WIDTH-1:0]   mat_b,
  output logic                       start,
  output logic [CW-1:0]              elem_count,
  output logic                       loader_busy,
  output logic                       overrun,
  output logic [1:0]                 dbg_state
);

  localparam int NA = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_n;
  logic                       r_s1, r_s2, r_s3;
  logic [CW-1:0]              r_count;
  logic [CW-1:0]              w_count_n;
  logic                       r_start, w_start_n;
  logic                       r_busy;
  logic                       r_overrun, w_overrun_n;
  logic                       w_capture;
  logic                       w_edge;
  logic                       w_accept;
  logic                       w_active;
  logic [DIM*DIM*WIDTH-1:0]   r_mat_a, r_mat_b;

  assign w_edge   = r_s2 & ~r_s3;
  assign w_active = (r_state == ISSUE) || (r_state == RUN);
  assign w_accept = w_edge & ena & ((r_state == IDLE) || (r_state == LOAD));

  // Strobe synchroniser; runs every cycle so enable does not swallow an edge mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= strobe_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next-state, element counter, start pulse and overrun flag; clear overrides everything.
  always_comb begin
    w_state_n   = r_state;
    w_count_n   = r_count;
    w_start_n   = 1'b0;
    w_overrun_n = r_overrun;
    w_capture   = 1'b0;
    if (clear) begin
      w_state_n   = IDLE;
      w_count_n   = '0;
      w_overrun_n = 1'b0;
    end else begin
      if (w_edge && ena && w_active) w_overrun_n = 1'b1;
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            w_capture = 1'b1;
            if (r_count < CW'(NELEM)) w_count_n = r_count + CW'(1);
            w_state_n = (r_count == CW'(NELEM - 1)) ? ISSUE : LOAD;
          end
        end
        ISSUE: begin
          if (ena && !core_busy) begin
            w_start_n = 1'b1;
            w_state_n = RUN;
          end
        end
        RUN: begin
          // core_done is honoured even while ena is low.
          if (core_done) begin
            w_state_n = IDLE;
            w_count_n = '0;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_count   <= w_count_n;
      r_start   <= w_start_n;
      r_busy    <= (w_state_n == ISSUE) || (w_state_n == RUN);
      r_overrun <= w_overrun_n;
    end
  end

  // Operand storage: only a captured byte writes, so matrices stay frozen in ISSUE/RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat_a <= '0;
      r_mat_b <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NA; i++) begin
        if (r_count == CW'(i))      r_mat_a[i*WIDTH +: WIDTH] <= data_in;
        if (r_count == CW'(i + NA)) r_mat_b[i*WIDTH +: WIDTH] <= data_in;
      end
    end
  end

  assign mat_a       = r_mat_a;
  assign mat_b       = r_mat_b;
  assign start       = r_start;
  assign elem_count  = r_count;
  assign loader_busy = r_busy;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mm_operand_loader.sv
// Directed bench for mm_operand_loader: reset, full loads, start timing,
// core_busy back-pressure, overrun, enable gating and clear priority.
module tb_mm_operand_loader;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  data_in;
  logic        strobe_in;
  logic        clear;
  logic        core_busy;
  logic        core_done;
  logic [31:0] mat_a;
  logic [31:0] mat_b;
  logic        start;
  logic [3:0]  elem_count;
  logic        loader_busy;
  logic        overrun;
  logic [1:0]  dbg_state;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int full_cyc  = 0;
  int prev_cnt  = 0;
  int sc;

  mm_operand_loader #(.DIM(2), .WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data_in     (data_in),
    .strobe_in   (strobe_in),
    .clear       (clear),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .mat_a       (mat_a),
    .mat_b       (mat_b),
    .start       (start),
    .elem_count  (elem_count),
    .loader_busy (loader_busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Start-pulse and load-complete timestamps, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (elem_count == 4'd8 && prev_cnt != 8) full_cyc = cyc;
    prev_cnt = int'(elem_count);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One byte: rise, hold through the capture edge, then low long enough to re-arm.
  task automatic strobe_byte(input logic [7:0] d);
    data_in   = d;
    strobe_in = 1'b1;
    repeat (3) tick();
    strobe_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
  endtask

  initial begin
    // Test 1: reset with strobe held high and data FF
    rst_n     = 1'b0;
    ena       = 1'b1;
    data_in   = 8'hFF;
    strobe_in = 1'b1;
    clear     = 1'b0;
    core_busy = 1'b0;
    core_done = 1'b0;
    repeat (2) tick();
    chk("rst_mat_a", mat_a, 32'h0);
    chk("rst_mat_b", mat_b, 32'h0);
    chk("rst_start", start, 1'b0);
    chk("rst_count", elem_count, 4'd0);
    chk("rst_busy", loader_busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t1_a00", mat_a[7:0], 8'hFF);
    chk("t1_count", elem_count, 4'd1);
    chk("t1_state", dbg_state, S_LOAD);
    repeat (4) tick();
    chk("t1_held_one_capture", elem_count, 4'd1);
    strobe_in = 1'b0;
    repeat (3) tick();
    pulse_clear();
    chk("t1_clear_count", elem_count, 4'd0);
    chk("t1_clear_a00_kept", mat_a[7:0], 8'hFF);

    // Test 2: load 1..8, start one cycle after the last capture
    sc = start_cnt;
    for (int i = 1; i <= 8; i++) strobe_byte(8'(i));
    chk("t2_mat_a", mat_a, 32'h04030201);
    chk("t2_mat_b", mat_b, 32'h08070605);
    chk("t2_start_once", start_cnt, sc + 1);
    chk("t2_start_latency", start_cyc - full_cyc, 1);
    chk("t2_state_run", dbg_state, S_RUN);
    chk("t2_busy", loader_busy, 1'b1);
    chk("t2_count_sat", elem_count, 4'd8);
    repeat (4) tick();
    chk("t2_busy_wait", loader_busy, 1'b1);
    chk("t2_no_restart", start_cnt, sc + 1);
    pulse_done();
    chk("t2_done_state", dbg_state, S_IDLE);
    chk("t2_done_busy", loader_busy, 1'b0);
    chk("t2_done_count", elem_count, 4'd0);

    // Test 3: core_busy holds off start in ISSUE
    core_busy = 1'b1;
    for (int i = 0; i < 8; i++) strobe_byte(8'(8'h10 + i));
    sc = start_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t3_issue_state", dbg_state, S_ISSUE);
      chk("t3_issue_start", start, 1'b0);
      chk("t3_issue_busy", loader_busy, 1'b1);
      tick();
    end
    chk("t3_no_start_yet", start_cnt, sc);
    core_busy = 1'b0;
    tick();
    chk("t3_start_high", start, 1'b1);
    chk("t3_state_run", dbg_state, S_RUN);
    core_busy = 1'b1;
    tick();
    chk("t3_start_low", start, 1'b0);
    chk("t3_start_once", start_cnt, sc + 1);
    chk("t3_run_ignores_busy", dbg_state, S_RUN);
    core_busy = 1'b0;
    chk("t3_mat_a", mat_a, 32'h13121110);
    chk("t3_mat_b", mat_b, 32'h17161514);

    // Test 4: strobe during RUN flags overrun, clear recovers
    strobe_byte(8'hAA);
    chk("t4_overrun", overrun, 1'b1);
    chk("t4_mat_b_kept", mat_b, 32'h17161514);
    chk("t4_state_run", dbg_state, S_RUN);
    chk("t4_count", elem_count, 4'd8);
    pulse_clear();
    chk("t4_clr_overrun", overrun, 1'b0);
    chk("t4_clr_state", dbg_state, S_IDLE);
    chk("t4_clr_count", elem_count, 4'd0);
    chk("t4_clr_busy", loader_busy, 1'b0);
    chk("t4_clr_mat_a", mat_a, 32'h13121110);
    chk("t4_clr_mat_b", mat_b, 32'h17161514);

    // Test 5: ena=0 ignores strobes
    ena = 1'b0;
    strobe_byte(8'h55);
    strobe_byte(8'h66);
    strobe_byte(8'h77);
    chk("t5_dis_count", elem_count, 4'd0);
    chk("t5_dis_state", dbg_state, S_IDLE);
    chk("t5_dis_mat_a", mat_a, 32'h13121110);
    chk("t5_dis_overrun", overrun, 1'b0);
    ena = 1'b1;
    tick();
    strobe_byte(8'h11);
    chk("t5_a00", mat_a, 32'h13121111);
    chk("t5_count", elem_count, 4'd1);

    // Test 6: clear on the capture edge drops the byte, then a clean reload
    strobe_byte(8'h22);
    strobe_byte(8'h33);
    chk("t6_count3", elem_count, 4'd3);
    chk("t6_mat_a3", mat_a, 32'h13332211);
    data_in   = 8'h44;
    strobe_in = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    strobe_in = 1'b0;
    repeat (2) tick();
    chk("t6_clr_count", elem_count, 4'd0);
    chk("t6_clr_state", dbg_state, S_IDLE);
    chk("t6_byte_dropped", mat_a, 32'h13332211);
    sc = start_cnt;
    for (int i = 0; i < 8; i++) strobe_byte(8'(8'h21 + i));
    chk("t6_mat_a", mat_a, 32'h24232221);
    chk("t6_mat_b", mat_b, 32'h28272625);
    chk("t6_start_once", start_cnt, sc + 1);
    chk("t6_start_latency", start_cyc - full_cyc, 1);
    chk("t6_state_run", dbg_state, S_RUN);
    pulse_done();
    chk("t6_done_state", dbg_state, S_IDLE);
    chk("t6_done_count", elem_count, 4'd0);
    chk("t6_overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
